store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/store_align.sv | 40 ++++
 rtl/store_buffer.sv | 119 +++++++++++
 tb/tb_store_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: store-type encodings, byte-strobe
// width and the layout of one queued store entry.
package store_buffer_pkg;

    // RISC-V store funct3 encodings accepted by the buffer
    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } funct3_e;

    localparam int unsigned STRB_W = 4;

    // One queued store: word address, lane-replicated data and byte enables
    typedef struct packed {
        logic [29:0]       addr;
        logic [31:0]       wdata;
        logic [STRB_W-1:0] wstrb;
    } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational store alignment: replicates store data across byte lanes,
// builds byte enables from the low address bits and flags illegal requests.
module store_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]        addr,
    input  logic [31:0]       data,
    input  logic [2:0]        funct3,
    output logic [31:0]       wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              bad
);

    // Lane replication, strobe generation and legality by store type
    always_comb begin
        wdata = '0;
        wstrb = '0;
        bad   = 1'b0;
        case (funct3)
            F3_SB: begin
                wdata = {4{data[7:0]}};
                wstrb = STRB_W'(1) << addr;
            end
            F3_SH: begin
                wdata = {2{data[15:0]}};
                wstrb = addr[1] ? 4'b1100 : 4'b0011;
                bad   = addr[0];
            end
            F3_SW: begin
                wdata = data;
                wstrb = '1;
                bad   = (addr != 2'b00);
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the memory stage and data memory. Accepted
// legal stores are aligned and queued; illegal ones are consumed and reported
// with a one-cycle misalign pulse. Also reports load/store word overlap.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [31:0]             s_addr,
    input  logic [31:0]             s_data,
    input  logic [2:0]              s_funct3,
    output logic                    misalign,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [31:0]             m_addr,
    output logic [31:0]             m_wdata,
    output logic [STRB_W-1:0]       m_wstrb,
    input  logic [31:0]             ld_check_addr,
    output logic                    ld_conflict,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    sb_entry_t         mem [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              mis_q;

    logic [31:0]       al_wdata;
    logic [STRB_W-1:0] al_wstrb;
    logic              al_bad;

    logic              accept;
    logic              enq;
    logic              deq;
    logic              unused_ld_low;

    store_align u_align (
        .addr   (s_addr[1:0]),
        .data   (s_data),
        .funct3 (s_funct3),
        .wdata  (al_wdata),
        .wstrb  (al_wstrb),
        .bad    (al_bad)
    );

    // Externally visible state is forced idle while rst is held, so the
    // first reset cycle already shows an empty, not-ready buffer.
    assign count    = rst ? '0 : cnt_q;
    assign s_ready  = !rst && (cnt_q != CNT_W'(DEPTH));
    assign m_valid  = !rst && (cnt_q != '0);
    assign misalign = !rst && mis_q;

    assign accept = s_valid && s_ready;
    assign enq    = accept && !al_bad;
    assign deq    = m_valid && m_ready;

    assign m_addr  = {mem[rd_ptr].addr, 2'b00};
    assign m_wdata = mem[rd_ptr].wdata;
    assign m_wstrb = mem[rd_ptr].wstrb;

    // Byte offset of the load is irrelevant: overlap is judged per word
    assign unused_ld_low = &{1'b0, ld_check_addr[1:0]};

    // Pointer, occupancy, per-slot valid and misalign pulse bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            mis_q <= accept && al_bad;
            if (enq) begin
                wr_ptr          <= wr_ptr + PTR_W'(1);
                valid_q[wr_ptr] <= 1'b1;
            end
            if (deq) begin
                rd_ptr          <= rd_ptr + PTR_W'(1);
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({enq, deq})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry payload capture; contents of free slots are don't-care
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr].addr  <= s_addr[31:2];
            mem[wr_ptr].wdata <= al_wdata;
            mem[wr_ptr].wstrb <= al_wstrb;
        end
    end

    // Word-address match of the load against every currently valid entry
    always_comb begin
        ld_conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i[PTR_W-1:0]] && (mem[i[PTR_W-1:0]].addr == ld_check_addr[31:2]))
                ld_conflict = 1'b1;
        end
        if (rst)
            ld_conflict = 1'b0;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed scenarios followed by random
// traffic, checked against a queue-based reference model of the buffer.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [2:0]  s_funct3;
    logic        misalign;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] ld_check_addr;
    logic        ld_conflict;
    logic [$clog2(DEPTH):0] count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mis_pend = 1'b0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_addr        (s_addr),
        .s_data        (s_data),
        .s_funct3      (s_funct3),
        .misalign      (misalign),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_wstrb       (m_wstrb),
        .ld_check_addr (ld_check_addr),
        .ld_conflict   (ld_conflict),
        .count         (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference store formation from the store-type rules; returns 1 if illegal
    function automatic logic model(input logic [31:0] a, input logic [31:0] d,
                                   input logic [2:0] f, output exp_t e);
        logic b;
        e.addr  = a & 32'hFFFF_FFFC;
        e.wdata = '0;
        e.strb  = '0;
        b       = 1'b0;
        case (f)
            3'd0: begin
                e.wdata = {24'd0, d[7:0]} * 32'h0101_0101;
                e.strb  = 4'(32'd1 << a[1:0]);
            end
            3'd1: begin
                e.wdata = {16'd0, d[15:0]} * 32'h0001_0001;
                e.strb  = a[1] ? 4'hC : 4'h3;
                b       = a[0];
            end
            3'd2: begin
                e.wdata = d;
                e.strb  = 4'hF;
                b       = (a[1:0] != 2'd0);
            end
            default: b = 1'b1;
        endcase
        return b;
    endfunction

    // Scoreboard: compare outputs with the model each cycle, pop on drain, push on accept
    always @(negedge clk) begin : scoreboard
        int   sz;
        logic exp_ready;
        logic exp_valid;
        logic exp_conf;
        logic bad;
        exp_t e;
        exp_t n;
        sz        = sbq.size();
        exp_ready = !rst && (sz != DEPTH);
        exp_valid = !rst && (sz != 0);
        exp_conf  = 1'b0;
        if (!rst)
            foreach (sbq[i])
                if (sbq[i].addr[31:2] == ld_check_addr[31:2])
                    exp_conf = 1'b1;
        check("s_ready",     32'(s_ready),     32'(exp_ready));
        check("m_valid",     32'(m_valid),     32'(exp_valid));
        check("count",       32'(count),       rst ? 32'd0 : 32'(sz));
        check("ld_conflict", 32'(ld_conflict), 32'(exp_conf));
        check("misalign",    32'(misalign),    32'(mis_pend && !rst));
        if (exp_valid && m_ready) begin
            e = sbq.pop_front();
            check("m_addr",  m_addr,        e.addr);
            check("m_wdata", m_wdata,       e.wdata);
            check("m_wstrb", 32'(m_wstrb),  32'(e.strb));
        end
        mis_pend = 1'b0;
        if (rst) begin
            sbq.delete();
        end else if (s_valid && exp_ready) begin
            bad = model(s_addr, s_data, s_funct3, n);
            if (bad) mis_pend = 1'b1;
            else     sbq.push_back(n);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        s_valid  = 1'b1;
        s_addr   = a;
        s_data   = d;
        s_funct3 = f;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_data = '0; s_funct3 = '0;
        m_ready = 1'b0; ld_check_addr = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Byte store at lane 3, drained immediately
        m_ready = 1'b1;
        req(32'h0000_1003, 32'h0000_00AB, 3'b000);
        repeat (2) step();

        // Misaligned halfword
        req(32'h0000_2001, 32'h1234_5678, 3'b001);
        repeat (2) step();

        // Fill past full with memory stalled, then drain
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            req(32'h0000_4000 + 32'(i * 4), $urandom, 3'b010);
        step();
        m_ready = 1'b1;
        repeat (6) step();

        // Load-overlap probe against two pending words
        m_ready = 1'b0;
        req(32'h0000_3000, 32'hAAAA_0000, 3'b010);
        req(32'h0000_3004, 32'hBBBB_0000, 3'b010);
        ld_check_addr = 32'h0000_3006;
        step();
        ld_check_addr = 32'h0000_3008;
        step();
        m_ready = 1'b1;
        repeat (3) step();

        // Steady enqueue+dequeue through pointer wrap
        m_ready = 1'b0;
        req(32'h0000_7000, $urandom, 3'b010);
        req(32'h0000_7004, $urandom, 3'b010);
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++)
            req(32'h0000_7100 + 32'(i * 4), $urandom, 3'b010);
        repeat (4) step();

        // Reset in the middle of a drain
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            req(32'h0000_8000 + 32'(i * 4), $urandom, 3'b010);
        m_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req(32'h0000_5000, 32'hC0FF_EE00, 3'b010);
        repeat (3) step();

        // Random traffic over a small address window so overlaps are frequent
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            s_valid       = ($urandom_range(0, 9) < 6);
            s_addr        = 32'h0000_6000 + 32'($urandom_range(0, 15));
            s_data        = $urandom;
            s_funct3      = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            m_ready       = $urandom_range(0, 1) == 1;
            ld_check_addr = 32'h0000_6000 + 32'($urandom_range(0, 19));
            step();
        end

        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        repeat (8) step();
        check("drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
